nios_button_pio: RTL and testbench

//  Avalon-MM slave input PIO: the CPU-read counterpart of the LED output PIOs.

---
 rtl/nios_button_pio.sv | 136 +++++++++++++
 tb/tb_nios_button_pio.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_button_pio.sv
// Avalon-MM input PIO: synchronised, debounced button lines with edge capture and masked IRQ.
// Debounce counters are built only when NIOS_BUTTON_PIO_DEBOUNCE_EN is defined.
module nios_button_pio #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] w1c_clr;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_d;
  logic             wr_en, rd_en;
  logic             unused_bits;

  // sync1_q feeds only sync2_q
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] deb_q, deb_d;

  // A line must disagree with deb for DEBOUNCE_CYCLES consecutive clocks to be accepted.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= RESET_LEVEL;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign deb = deb_q;
`else
  assign deb = sync2_q;
`endif

  always_comb begin
    unique case (EDGE_TYPE)
      0:       edge_evt = deb & ~prev_q;
      1:       edge_evt = ~deb & prev_q;
      default: edge_evt = deb ^ prev_q;
    endcase
  end

  assign wr_en   = chipselect & ~write_n;
  assign rd_en   = chipselect & ~read_n;
  assign w1c_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_en && address == 2'd2) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    // A fresh edge wins over a simultaneous W1C clear.
    edge_cap_d = (edge_cap_q & ~w1c_clr) | edge_evt;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = deb;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask_q;
      2'd3:    rd_mux[WIDTH-1:0] = edge_cap_q;
      default: rd_mux = '0;
    endcase
    readdata_d = rd_en ? rd_mux : 32'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= RESET_LEVEL;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata   <= '0;
    end else begin
      prev_q     <= deb;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata   <= readdata_d;
    end
  end

  assign irq = |(edge_cap_q & irq_mask_q);

  assign unused_bits = ^{writedata, 32'(DEBOUNCE_CYCLES)};

endmodule

// File: tb/tb_nios_button_pio.sv
// Directed self-checking bench for nios_button_pio (WIDTH=4, DEBOUNCE_CYCLES=8, falling edges).
// Runs the debounce scenarios when NIOS_BUTTON_PIO_DEBOUNCE_EN is defined, pass-through otherwise.
module tb_nios_button_pio;

`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
  localparam int Lat = 10;
  localparam int MidDeb = 7;
`else
  localparam int Lat = 2;
  localparam int MidDeb = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int tests_run;
  int tests_failed;

  nios_button_pio #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(8),
    .EDGE_TYPE      (1),
    .RESET_LEVEL    (4'hF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .read_n    (read_n),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    @(posedge clk);
    #1;
    d          = readdata;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    do_read(a, d);
    tests_run++;
    if (d !== exp) begin
      tests_failed++;
      $display("FAIL %s: readdata=0x%08h expected 0x%08h", name, d, exp);
    end
  endtask

  task automatic test_reset;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: readdata=0x%08h irq=%b expected 0 0", readdata, irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    chk_rd("reset_data", 2'd0, 32'hF);
    chk_rd("reset_dir", 2'd1, 32'h0);
    chk_rd("reset_mask", 2'd2, 32'h0);
    chk_rd("reset_edgecap", 2'd3, 32'h0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_irq: irq=%b expected 0", irq);
    end
  endtask

  task automatic test_bit0_mask;
    @(negedge clk);
    in_port = 4'hE;
    repeat (Lat) @(posedge clk);
    chk_rd("bit0_data", 2'd0, 32'hE);
    chk_rd("bit0_edgecap", 2'd3, 32'h1);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL bit0_irq_masked: irq=%b expected 0", irq);
    end
    do_write(2'd2, 32'h1);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL bit0_irq_unmasked: irq=%b expected 1", irq);
    end
    do_write(2'd2, 32'h0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL bit0_irq_mask_clear: irq=%b expected 0", irq);
    end
    do_write(2'd3, 32'h1);
    chk_rd("bit0_w1c", 2'd3, 32'h0);
    @(negedge clk);
    in_port = 4'hF;
    repeat (Lat + 3) @(posedge clk);
    chk_rd("bit0_rise_data", 2'd0, 32'hF);
    chk_rd("bit0_rise_ignored", 2'd3, 32'h0);
  endtask

`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
  task automatic test_glitch;
    @(negedge clk);
    in_port = 4'hE;
    repeat (5) @(posedge clk);
    @(negedge clk);
    in_port = 4'hF;
    repeat (15) @(posedge clk);
    chk_rd("glitch_data", 2'd0, 32'hF);
    chk_rd("glitch_edgecap", 2'd3, 32'h0);
  endtask
`endif

  task automatic test_fall_irq;
    @(negedge clk);
    in_port = 4'hB;
    repeat (Lat - 1) @(posedge clk);
    chk_rd("fall_before", 2'd0, 32'hF);
    chk_rd("fall_after", 2'd0, 32'hB);
    chk_rd("fall_edgecap", 2'd3, 32'h4);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL fall_irq_masked: irq=%b expected 0", irq);
    end
    do_write(2'd2, 32'h4);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL fall_irq: irq=%b expected 1", irq);
    end
    chk_rd("fall_mask", 2'd2, 32'h4);
    repeat (10) @(posedge clk);
    @(negedge clk);
    in_port = 4'hF;
    repeat (Lat + 3) @(posedge clk);
    chk_rd("rise_data", 2'd0, 32'hF);
    chk_rd("rise_edgecap_kept", 2'd3, 32'h4);
  endtask

  task automatic test_set_wins;
    @(negedge clk);
    in_port = 4'hB;
    repeat (Lat) @(posedge clk);
    do_write(2'd3, 32'h4);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL setwins_irq: irq=%b expected 1", irq);
    end
    chk_rd("setwins_edgecap", 2'd3, 32'h4);
    do_write(2'd3, 32'h4);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1c_irq: irq=%b expected 0", irq);
    end
    chk_rd("w1c_edgecap", 2'd3, 32'h0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_port = 4'hF;
    repeat (Lat + 3) @(posedge clk);
    do_write(2'd2, 32'hF);
    @(negedge clk);
    in_port = 4'hB;
    repeat (MidDeb) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_rd("midrst_data", 2'd0, 32'hF);
    chk_rd("midrst_edgecap", 2'd3, 32'h0);
    chk_rd("midrst_mask", 2'd2, 32'h0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_irq: irq=%b expected 0", irq);
    end
    repeat (Lat + 3) @(posedge clk);
    chk_rd("midrst_relearn", 2'd0, 32'hB);
    chk_rd("midrst_edge_after", 2'd3, 32'h4);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_bit0_mask();
`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
    test_glitch();
`endif
    test_fall_irq();
    test_set_wins();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
